// File: rtl/rr_arbiter8_if.sv
// rtl/rr_arbiter8_if.sv - request/grant bundle between requesters and the 8-way arbiter
interface rr_arbiter8_if;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    modport master (
        output req,
        input  gnt,
        input  gnt_idx,
        input  gnt_valid,
        input  timeout
    );

    modport slave (
        input  req,
        output gnt,
        output gnt_idx,
        output gnt_valid,
        output timeout
    );
endinterface

// File: rtl/rr_arbiter8.sv
// rtl/rr_arbiter8.sv - 8-requester round-robin arbiter with bounded hold time
// Grant is held while the owner keeps requesting, revoked after MAX_HOLD cycles (0 = unlimited).
module rr_arbiter8 #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 8
) (
    input  logic          clk,
    input  logic          rst,
    rr_arbiter8_if.slave  arb
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RECOVER = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LIMIT = CNT_W'(MAX_HOLD);
    localparam bit               HOLD_BOUND = (MAX_HOLD != 0);

    state_t           state;
    logic [2:0]       ptr;
    logic [CNT_W-1:0] hold_cnt;
    logic [2:0]       sel_idx;

    // Scan from the top offset down so the nearest set bit at or after ptr wins.
    always_comb begin
        logic [2:0] cand;
        cand    = 3'd0;
        sel_idx = ptr;
        for (int k = 7; k >= 0; k--) begin
            cand = ptr + 3'(k);
            if (arb.req[cand]) begin
                sel_idx = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            ptr           <= 3'd0;
            hold_cnt      <= '0;
            arb.gnt       <= 8'h00;
            arb.gnt_idx   <= 3'd0;
            arb.gnt_valid <= 1'b0;
            arb.timeout   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    arb.timeout <= 1'b0;
                    if (|arb.req) begin
                        arb.gnt       <= 8'b1 << sel_idx;
                        arb.gnt_idx   <= sel_idx;
                        arb.gnt_valid <= 1'b1;
                        hold_cnt      <= CNT_W'(1);
                        state         <= GRANT;
                    end
                end
                GRANT: begin
                    if (!arb.req[arb.gnt_idx] || (HOLD_BOUND && hold_cnt == HOLD_LIMIT)) begin
                        // Just-served requester drops to lowest priority next round.
                        ptr           <= arb.gnt_idx + 3'd1;
                        arb.timeout   <= arb.req[arb.gnt_idx];
                        arb.gnt       <= 8'h00;
                        arb.gnt_idx   <= 3'd0;
                        arb.gnt_valid <= 1'b0;
                        state         <= RECOVER;
                    end else if (hold_cnt != '1) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                RECOVER: begin
                    arb.timeout <= 1'b0;
                    hold_cnt    <= '0;
                    state       <= IDLE;
                end
                default: begin
                    state         <= IDLE;
                    hold_cnt      <= '0;
                    arb.gnt       <= 8'h00;
                    arb.gnt_idx   <= 3'd0;
                    arb.gnt_valid <= 1'b0;
                    arb.timeout   <= 1'b0;
                end
            endcase
        end
    end

    a_gnt_onehot0 : assert property (@(posedge clk) disable iff (rst) $onehot0(arb.gnt));
    a_gnt_matches : assert property (@(posedge clk) disable iff (rst)
                                     arb.gnt_valid |-> arb.gnt[arb.gnt_idx]);
    a_to_excl     : assert property (@(posedge clk) disable iff (rst)
                                     !(arb.timeout && arb.gnt_valid));
endmodule

// File: tb/tb_rr_arbiter8.sv
// tb/tb_rr_arbiter8.sv - directed self-checking bench for rr_arbiter8
module tb_rr_arbiter8;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    rr_arbiter8_if if4 ();
    rr_arbiter8_if if16 ();
    rr_arbiter8_if if0 ();

    rr_arbiter8 #(.MAX_HOLD(4))  u4  (.clk(clk), .rst(rst), .arb(if4));
    rr_arbiter8 #(.MAX_HOLD(16)) u16 (.clk(clk), .rst(rst), .arb(if16));
    rr_arbiter8 #(.MAX_HOLD(0))  u0  (.clk(clk), .rst(rst), .arb(if0));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Outputs are inspected 1 time unit after the rising edge; inputs change there too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        checks++;
        if ({if4.gnt, if4.gnt_idx, if4.gnt_valid, if4.timeout} !== 13'd0) begin
            errors++;
            $display("FAIL reset_u4: got %h expected %h", {if4.gnt, if4.gnt_idx, if4.gnt_valid, if4.timeout}, 13'd0);
        end
        checks++;
        if ({if16.gnt, if16.gnt_idx, if16.gnt_valid, if16.timeout} !== 13'd0) begin
            errors++;
            $display("FAIL reset_u16: got %h expected %h", {if16.gnt, if16.gnt_idx, if16.gnt_valid, if16.timeout}, 13'd0);
        end
        checks++;
        if ({if0.gnt, if0.gnt_idx, if0.gnt_valid, if0.timeout} !== 13'd0) begin
            errors++;
            $display("FAIL reset_u0: got %h expected %h", {if0.gnt, if0.gnt_idx, if0.gnt_valid, if0.timeout}, 13'd0);
        end
    endtask

    task automatic test_single_request();
        if16.req = 8'h08;
        step();
        checks++;
        if ({if16.gnt, if16.gnt_idx, if16.gnt_valid, if16.timeout} !== {8'h08, 3'd3, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL single_grant: got %h expected %h", {if16.gnt, if16.gnt_idx, if16.gnt_valid, if16.timeout}, {8'h08, 3'd3, 1'b1, 1'b0});
        end
        if16.req = 8'h00;
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if ({if16.gnt, if16.gnt_idx, if16.gnt_valid, if16.timeout} !== 13'd0) begin
                errors++;
                $display("FAIL single_release c=%0d: got %h expected %h", c, {if16.gnt, if16.gnt_idx, if16.gnt_valid, if16.timeout}, 13'd0);
            end
        end
    endtask

    task automatic test_round_robin();
        logic [2:0]  idx;
        logic [7:0]  g;
        logic [12:0] exp;
        if4.req = 8'hFF;
        for (int n = 0; n < 9; n++) begin
            idx = 3'(n % 8);
            g   = 8'h01 << idx;
            exp = {g, idx, 1'b1, 1'b0};
            for (int c = 0; c < 4; c++) begin
                step();
                checks++;
                if ({if4.gnt, if4.gnt_idx, if4.gnt_valid, if4.timeout} !== exp) begin
                    errors++;
                    $display("FAIL rr_grant n=%0d c=%0d: got %h expected %h", n, c, {if4.gnt, if4.gnt_idx, if4.gnt_valid, if4.timeout}, exp);
                end
            end
            step();
            checks++;
            if ({if4.gnt, if4.gnt_idx, if4.gnt_valid, if4.timeout} !== 13'd1) begin
                errors++;
                $display("FAIL rr_timeout n=%0d: got %h expected %h", n, {if4.gnt, if4.gnt_idx, if4.gnt_valid, if4.timeout}, 13'd1);
            end
            step();
            checks++;
            if ({if4.gnt, if4.gnt_idx, if4.gnt_valid, if4.timeout} !== 13'd0) begin
                errors++;
                $display("FAIL rr_gap n=%0d: got %h expected %h", n, {if4.gnt, if4.gnt_idx, if4.gnt_valid, if4.timeout}, 13'd0);
            end
            if (n == 8) if4.req = 8'h00;
        end
        step();
    endtask

    task automatic test_wrap_pointer();
        logic [7:0] reqs [3];
        logic [2:0] want [3];
        reqs = '{8'h40, 8'h41, 8'h41};
        want = '{3'd6, 3'd0, 3'd6};
        for (int t = 0; t < 3; t++) begin
            if4.req = reqs[t];
            step();
            checks++;
            if ({if4.gnt_idx, if4.gnt_valid} !== {want[t], 1'b1}) begin
                errors++;
                $display("FAIL wrap t=%0d: got idx=%0d valid=%b expected idx=%0d valid=1", t, if4.gnt_idx, if4.gnt_valid, want[t]);
            end
            if4.req = 8'h00;
            step();
            step();
        end
    endtask

    task automatic test_hold_timeout();
        if16.req = 8'h20;
        for (int c = 1; c <= 16; c++) begin
            step();
            checks++;
            if ({if16.gnt, if16.gnt_idx, if16.gnt_valid, if16.timeout} !== {8'h20, 3'd5, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL hold c=%0d: got %h expected %h", c, {if16.gnt, if16.gnt_idx, if16.gnt_valid, if16.timeout}, {8'h20, 3'd5, 1'b1, 1'b0});
            end
        end
        step();
        checks++;
        if ({if16.gnt, if16.gnt_idx, if16.gnt_valid, if16.timeout} !== 13'd1) begin
            errors++;
            $display("FAIL hold_timeout: got %h expected %h", {if16.gnt, if16.gnt_idx, if16.gnt_valid, if16.timeout}, 13'd1);
        end
        step();
        checks++;
        if ({if16.gnt, if16.gnt_idx, if16.gnt_valid, if16.timeout} !== 13'd0) begin
            errors++;
            $display("FAIL hold_gap: got %h expected %h", {if16.gnt, if16.gnt_idx, if16.gnt_valid, if16.timeout}, 13'd0);
        end
        step();
        checks++;
        if ({if16.gnt, if16.gnt_idx, if16.gnt_valid, if16.timeout} !== {8'h20, 3'd5, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL hold_regrant: got %h expected %h", {if16.gnt, if16.gnt_idx, if16.gnt_valid, if16.timeout}, {8'h20, 3'd5, 1'b1, 1'b0});
        end
        if16.req = 8'h00;
        step();
        step();
    endtask

    task automatic test_reset_mid_grant();
        if4.req = 8'h04;
        step();
        checks++;
        if ({if4.gnt, if4.gnt_idx, if4.gnt_valid} !== {8'h04, 3'd2, 1'b1}) begin
            errors++;
            $display("FAIL midrst_grant: got %h expected %h", {if4.gnt, if4.gnt_idx, if4.gnt_valid}, {8'h04, 3'd2, 1'b1});
        end
        rst     = 1'b1;
        if4.req = 8'h06;
        step();
        rst = 1'b0;
        checks++;
        if ({if4.gnt, if4.gnt_idx, if4.gnt_valid, if4.timeout} !== 13'd0) begin
            errors++;
            $display("FAIL midrst_clear: got %h expected %h", {if4.gnt, if4.gnt_idx, if4.gnt_valid, if4.timeout}, 13'd0);
        end
        step();
        checks++;
        if ({if4.gnt, if4.gnt_idx, if4.gnt_valid, if4.timeout} !== {8'h02, 3'd1, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL midrst_ptr: got %h expected %h", {if4.gnt, if4.gnt_idx, if4.gnt_valid, if4.timeout}, {8'h02, 3'd1, 1'b1, 1'b0});
        end
        if4.req = 8'h00;
        step();
        step();
    endtask

    task automatic test_unlimited_hold();
        if0.req = 8'h08;
        for (int i = 0; i < 300; i++) begin
            step();
            checks++;
            if ({if0.gnt, if0.gnt_idx, if0.gnt_valid, if0.timeout} !== {8'h08, 3'd3, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL unlimited i=%0d: got %h expected %h", i, {if0.gnt, if0.gnt_idx, if0.gnt_valid, if0.timeout}, {8'h08, 3'd3, 1'b1, 1'b0});
            end
            if0.req = 8'h08 | 8'(i & 1);
        end
        if0.req = 8'h00;
        step();
        checks++;
        if ({if0.gnt, if0.gnt_idx, if0.gnt_valid, if0.timeout} !== 13'd0) begin
            errors++;
            $display("FAIL unlimited_release: got %h expected %h", {if0.gnt, if0.gnt_idx, if0.gnt_valid, if0.timeout}, 13'd0);
        end
        step();
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        if4.req  = 8'h00;
        if16.req = 8'h00;
        if0.req  = 8'h00;
        test_reset();
        test_single_request();
        test_round_robin();
        test_wrap_pointer();
        test_hold_timeout();
        test_reset_mid_grant();
        test_unlimited_hold();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
